// File: rtl/cache_pkg.sv
// Shared cache definitions: address field boundaries, set count,
// reference-driver state encoding and cache_state encodings.
package cache_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned OFFSET_MSB = 2;
  localparam int unsigned OFFSET_LSB = 0;
  localparam int unsigned INDEX_MSB  = 6;
  localparam int unsigned INDEX_LSB  = 3;
  localparam int unsigned TAG_MSB    = 31;
  localparam int unsigned TAG_LSB    = 7;
  localparam int unsigned INDEX_W    = INDEX_MSB - INDEX_LSB + 1;
  localparam int unsigned NUM_SETS   = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_ALLOC  = 2'd2
  } drv_state_e;

  typedef enum logic {
    CS_LOOKUP = 1'b0,
    CS_ALLOC  = 1'b1
  } cache_state_e;

  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
    return addr[INDEX_MSB:INDEX_LSB];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/ref_driver.sv
// Memory-reference driver: feeds one reference at a time to the cache and
// reports hit/miss. Define REF_DRIVER_ALLOC_EN to route misses through ALLOC.
module ref_driver
  import cache_pkg::*;
#(
  parameter int unsigned COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ref_valid,
  input  logic [31:0]        ref_addr,
  output logic               ref_ready,
  input  logic               clr_stats,
  output logic [31:0]        cache_addr,
  output logic               cache_state,
  input  logic               cache_hit,
  output logic               res_valid,
  output logic               res_hit,
  output logic [3:0]         res_index,
  output logic [COUNT_W-1:0] hit_count,
  output logic [COUNT_W-1:0] miss_count
);

  drv_state_e         state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic               res_valid_q, res_valid_d;
  logic               res_hit_q, res_hit_d;
  logic [INDEX_W-1:0] res_index_q, res_index_d;
  logic               hit_inc, miss_inc;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    res_valid_d = 1'b0;
    res_hit_d   = res_hit_q;
    res_index_d = res_index_q;
    hit_inc     = 1'b0;
    miss_inc    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ref_valid) begin
          addr_d  = ref_addr;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        // Result and statistics are registered here so they appear together
        // in the cycle after the lookup.
        res_valid_d = 1'b1;
        res_hit_d   = cache_hit;
        res_index_d = addr_index(addr_q);
        hit_inc     = cache_hit;
        miss_inc    = !cache_hit;
`ifdef REF_DRIVER_ALLOC_EN
        state_d     = cache_hit ? ST_IDLE : ST_ALLOC;
`else
        state_d     = ST_IDLE;
`endif
      end
      ST_ALLOC: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      res_valid_q <= 1'b0;
      res_hit_q   <= 1'b0;
      res_index_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      res_valid_q <= res_valid_d;
      res_hit_q   <= res_hit_d;
      res_index_q <= res_index_d;
    end
  end

  assign ref_ready  = (state_q == ST_IDLE);
  assign cache_addr = addr_q;
  assign res_valid  = res_valid_q;
  assign res_hit    = res_hit_q;
  assign res_index  = res_index_q;

`ifdef REF_DRIVER_ALLOC_EN
  assign cache_state = (state_q == ST_ALLOC) ? CS_ALLOC : CS_LOOKUP;
`else
  assign cache_state = CS_LOOKUP;
`endif

  sat_counter #(.WIDTH(COUNT_W)) u_hit_cnt (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .inc_i   (hit_inc),
    .clr_i   (clr_stats),
    .count_o (hit_count)
  );

  sat_counter #(.WIDTH(COUNT_W)) u_miss_cnt (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .inc_i   (miss_inc),
    .clr_i   (clr_stats),
    .count_o (miss_count)
  );

endmodule

// File: tb/tb_ref_driver.sv
// Scoreboard bench for ref_driver (COUNT_W = 4) with a small direct-mapped cache model.
module tb_ref_driver;

`ifdef REF_DRIVER_ALLOC_EN
  localparam bit ALLOC_EN = 1'b1;
`else
  localparam bit ALLOC_EN = 1'b0;
`endif
  localparam int unsigned CW = 4;

  logic          clk;
  logic          rst_n;
  logic          ref_valid;
  logic [31:0]   ref_addr;
  logic          ref_ready;
  logic          clr_stats;
  logic [31:0]   cache_addr;
  logic          cache_state;
  logic          cache_hit;
  logic          res_valid;
  logic          res_hit;
  logic [3:0]    res_index;
  logic [CW-1:0] hit_count;
  logic [CW-1:0] miss_count;

  ref_driver #(.COUNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ref_valid  (ref_valid),
    .ref_addr   (ref_addr),
    .ref_ready  (ref_ready),
    .clr_stats  (clr_stats),
    .cache_addr (cache_addr),
    .cache_state(cache_state),
    .cache_hit  (cache_hit),
    .res_valid  (res_valid),
    .res_hit    (res_hit),
    .res_index  (res_index),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Direct-mapped cache: filled when the driver sits in ALLOC, emptied on reset.
  logic [15:0] vld_m;
  logic [24:0] tag_m [16];
  assign cache_hit = vld_m[cache_addr[6:3]] && (tag_m[cache_addr[6:3]] == cache_addr[31:7]);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_m <= '0;
    end else if (cache_state) begin
      vld_m[cache_addr[6:3]] <= 1'b1;
      tag_m[cache_addr[6:3]] <= cache_addr[31:7];
    end
  end

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } res_t;

  res_t       sbq[$];
  res_t       mon_e;
  logic [3:0] last_idx;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         exp_h   = 0;
  int         exp_m   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      last_idx = '0;
    end else if (res_valid) begin
      if (sbq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got res_valid=1, expected 0 (nothing outstanding)");
      end else begin
        mon_e = sbq.pop_front();
        chk("res_hit", 32'(res_hit), 32'(mon_e.hit));
        chk("res_index", 32'(res_index), 32'(mon_e.idx));
        last_idx = mon_e.idx;
      end
    end else begin
      chk("res_index_hold", 32'(res_index), 32'(last_idx));
    end
  end

  // Entered and left at a negedge. mode: 0 none, 1 clr during LOOKUP, 2 clr during result cycle.
  task automatic send(input logic [31:0] addr, input bit hit_if_alloc, input int mode);
    bit   eh;
    int   busy;
    int   allocs;
    int   w;
    res_t e;
    eh = ALLOC_EN && hit_if_alloc;
    w = 0;
    while (ref_ready !== 1'b1 && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("ready_before_send", 32'(ref_ready), 32'd1);
    ref_valid = 1'b1;
    ref_addr  = addr;
    e.hit = eh;
    e.idx = addr[6:3];
    sbq.push_back(e);
    @(posedge clk); #1;
    ref_valid = 1'b0;
    ref_addr  = $urandom;
    clr_stats = (mode == 1);
    @(posedge clk); #1;
    clr_stats = (mode == 2);
    busy = 1;
    allocs = 0;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      chk("cache_addr_held", cache_addr, addr);
      if (cache_state) allocs++;
      if (ref_ready) break;
      busy++;
      @(negedge clk);
    end
    chk("ready_after_ref", 32'(ref_ready), 32'd1);
    if (clr_stats) begin
      if (busy == 1) begin
        @(posedge clk); #1;
      end
      clr_stats = 1'b0;
      @(negedge clk);
    end
    if (mode != 0) begin
      exp_h = 0;
      exp_m = 0;
    end else if (eh) begin
      exp_h = sat(exp_h + 1);
    end else begin
      exp_m = sat(exp_m + 1);
    end
    chk("hit_count", 32'(hit_count), 32'(exp_h));
    chk("miss_count", 32'(miss_count), 32'(exp_m));
    chk("busy_cycles", 32'(busy), (eh || !ALLOC_EN) ? 32'd1 : 32'd2);
    chk("alloc_cycles", 32'(allocs), (!eh && ALLOC_EN) ? 32'd1 : 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] vec_addr [8] = '{32'h0000_0080, 32'h0000_0080, 32'h0000_1238, 32'h0000_1238,
                                32'h0000_00FF, 32'h0000_0080, 32'h1000_0080, 32'h0000_0080};
  bit          vec_hit  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    int          acc;
    logic [31:0] a;
    logic [31:0] cap;
    rst_n     = 1'b0;
    ref_valid = 1'b0;
    ref_addr  = '0;
    clr_stats = 1'b0;
    #2;
    chk("rst_ref_ready", 32'(ref_ready), 32'd1);
    chk("rst_cache_addr", cache_addr, 32'd0);
    chk("rst_cache_state", 32'(cache_state), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_hit", 32'(res_hit), 32'd0);
    chk("rst_res_index", 32'(res_index), 32'd0);
    chk("rst_hit_count", 32'(hit_count), 32'd0);
    chk("rst_miss_count", 32'(miss_count), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) send(vec_addr[i], vec_hit[i], 0);

    // ref_valid held with a fresh address every cycle; only IDLE offers are taken.
    ref_valid = 1'b1;
    acc = 0;
    cap = 32'h0000_0080;
    for (int c = 0; c < 12; c++) begin
      a = 32'h0002_0000 + 32'(c) * 32'h88;
      ref_addr = a;
      chk("ready_pattern", 32'(ref_ready), ALLOC_EN ? 32'(c % 3 == 0) : 32'(c % 2 == 0));
      if (ref_ready) begin
        cap = a;
        acc++;
        sbq.push_back('{hit: 1'b0, idx: a[6:3]});
        exp_m = sat(exp_m + 1);
      end
      @(posedge clk); #1;
      chk("held_capture", cache_addr, cap);
      @(negedge clk);
    end
    ref_valid = 1'b0;
    chk("held_accept_count", 32'(acc), ALLOC_EN ? 32'd4 : 32'd6);
    chk("held_miss_count", 32'(miss_count), 32'(exp_m));

    send(32'h0000_1238, 1'b1, 2);
    send(32'h0000_00FF, 1'b1, 1);
    chk("cleared_hit_count", 32'(hit_count), 32'd0);

    for (int i = 0; i < 20; i++) send(32'h4000_0000 + 32'(i) * 32'h80, 1'b0, 0);
    chk("miss_saturated", 32'(miss_count), 32'd15);
    chk("hit_after_misses", 32'(hit_count), 32'd0);

    // Reset in the middle of a miss (ALLOC if present, else LOOKUP).
    ref_valid = 1'b1;
    ref_addr  = 32'h5000_0000;
    if (ALLOC_EN) sbq.push_back('{hit: 1'b0, idx: 4'd0});
    @(posedge clk); #1;
    ref_valid = 1'b0;
    if (ALLOC_EN) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("in_alloc_state", 32'(cache_state), 32'd1);
    end else begin
      @(negedge clk);
    end
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cache_addr", cache_addr, 32'd0);
    chk("mid_rst_cache_state", 32'(cache_state), 32'd0);
    chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_res_hit", 32'(res_hit), 32'd0);
    chk("mid_rst_res_index", 32'(res_index), 32'd0);
    chk("mid_rst_hit_count", 32'(hit_count), 32'd0);
    chk("mid_rst_miss_count", 32'(miss_count), 32'd0);
    chk("mid_rst_ref_ready", 32'(ref_ready), 32'd1);
    exp_h = 0;
    exp_m = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abandoned_no_pending", 32'(sbq.size()), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("abandoned_no_result", 32'(res_valid), 32'd0);
    end
    send(32'h0000_1238, 1'b0, 0);
    send(32'h0000_1238, 1'b1, 0);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ref_driver.md
REF_DRIVER -- requirements
Module: ref_driver

Interface
REQ-001 SHALL have parameter COUNT_W, default 32, width of each statistics counter (legal 4..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ref_valid  input  1  upstream memory reference offered.
REQ-005 SHALL have port ref_addr  input  32  upstream reference address.
REQ-006 SHALL have port ref_ready  output  1  driver can accept a reference this cycle.
REQ-007 SHALL have port clr_stats  input  1  synchronous clear of both counters.
REQ-008 SHALL have port cache_addr  output  32  address presented to the cache.
REQ-009 SHALL have port cache_state  output  1  cache FSM state: 0 = lookup, 1 = allocate.
REQ-010 SHALL have port cache_hit  input  1  hit indication returned by the cache.
REQ-011 SHALL have port res_valid  output  1  one-cycle pulse, reference result available.
REQ-012 SHALL have port res_hit  output  1  result of the completed reference.
REQ-013 SHALL have port res_index  output  4  set index (addr[6:3]) of the completed reference.
REQ-014 SHALL have ports hit_count, miss_count  output  COUNT_W  saturating statistics.

Function
REQ-015 SHALL implement FSM states IDLE, LOOKUP, ALLOC; ref_ready = 1 only in IDLE.
REQ-016 IDLE: on ref_valid && ref_ready, SHALL latch ref_addr into cache_addr and enter LOOKUP; otherwise stay IDLE, cache_addr unchanged.
REQ-017 LOOKUP: cache_state = 0; SHALL sample cache_hit at the end of this single cycle.
REQ-018 LOOKUP with hit: next cycle res_valid = 1, res_hit = 1, hit_count += 1, return to IDLE.
REQ-019 LOOKUP with miss: next cycle res_valid = 1, res_hit = 0, miss_count += 1, enter ALLOC (when REQ-030 applies).
REQ-020 ALLOC: cache_state = 1 for exactly one cycle with cache_addr held, then IDLE.
REQ-021 Throughput: hit = 2 cycles/reference, miss = 3 cycles/reference; no new reference accepted outside IDLE.
REQ-022 res_index SHALL equal cache_addr[6:3] while res_valid is high and hold its value otherwise.
REQ-023 Counters SHALL saturate at 2^COUNT_W-1; no wrap-around.
REQ-024 clr_stats coincident with an increment: clear wins, counter reads 0 next cycle.
REQ-025 ref_valid held or ref_addr changed while not in IDLE SHALL have no effect.

Reset
REQ-026 rst_n low SHALL force, asynchronously: state IDLE, cache_addr 0, cache_state 0, res_valid 0, res_hit 0, res_index 0, hit_count 0, miss_count 0.
REQ-027 ref_ready SHALL be 1 during reset.
REQ-028 Reset asserted mid-LOOKUP or mid-ALLOC SHALL abandon the reference with no result pulse and no counter update.
REQ-029 Leaving reset SHALL require no initialisation cycles; first reference accepted on first rising edge with rst_n high.

Configuration
REQ-030 With REF_DRIVER_ALLOC_EN defined, misses SHALL pass through ALLOC per REQ-019/020.
REQ-031 Without REF_DRIVER_ALLOC_EN, a miss SHALL return directly to IDLE; cache_state SHALL be constant 0 and ALLOC unreachable; miss throughput 2 cycles.

Structure
REQ-032 Shared package cache_pkg SHALL hold address field constants (OFFSET 2:0, INDEX 6:3, TAG 31:7), NUM_SETS = 16, state-encoding typedef, cache_state encodings.
REQ-033 Counters SHALL be two instances of sub-module sat_counter (width parameter, inc, clr, saturate).

Verification
REQ-034 Reset, then ref 0x0000_0080 into empty cache -> res_hit 0, one ALLOC cycle with cache_state 1, miss_count 1; same address again -> res_hit 1, hit_count 1, res_index 0.
REQ-035 ref_valid held high with new addresses throughout -> ref_ready low in LOOKUP/ALLOC, only addresses offered in IDLE cycles captured.
REQ-036 COUNT_W = 4, 20 misses to distinct tags -> miss_count stops at 15.
REQ-037 clr_stats on same cycle as res_valid for a hit -> hit_count 0 next cycle.
REQ-038 rst_n pulsed low during ALLOC -> all outputs 0 immediately, no res_valid, counters 0.
REQ-039 REF_DRIVER_ALLOC_EN undefined, same address twice -> two misses, cache_state never 1, each in 2 cycles.
